dmem_arbiter: RTL and testbench

- Two-port round-robin arbiter and sequencer in front of the single-port data memory.
- Port 0 is the core load/store unit; port 1 is the debug/DMA loader.
- Serialises accesses into one memory cycle each and registers read data for the requester.
- Supports locked back-to-back accesses (read-modify-write) and rejects misaligned addresses.

---
 rtl/dmem_arbiter.sv | 117 +++++++++++
 tb/tb_dmem_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter/sequencer in front of a single-port data memory.
// Define DMEM_ARB_FIXED_PRIO_EN to make port 0 win simultaneous requests instead of round robin.
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic              m0_err,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic              m1_err,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addrs,
    output logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] mem_data_out
);
    typedef enum logic [1:0] {IDLE, SERVE0, SERVE1} state_t;
    localparam int CW = $clog2(LOCK_MAX + 1);

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic [CW-1:0]     lock_cnt_q, lock_cnt_d;
    logic              rvalid0_q, rvalid1_q, err0_q, err1_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    logic              serve, sel, we_s, lock_s, req_s, aligned, load_ok, pick;
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] wdata_s;

    assign serve   = state_q != IDLE;
    assign sel     = state_q == SERVE1;
    assign addr_s  = sel ? m1_addr : m0_addr;
    assign wdata_s = sel ? m1_wdata : m0_wdata;
    assign we_s    = sel ? m1_we : m0_we;
    assign lock_s  = sel ? m1_lock : m0_lock;
    assign req_s   = sel ? m1_req : m0_req;
    assign aligned = addr_s[1:0] == 2'b00;
    assign load_ok = serve & ~we_s & aligned;

    assign m0_gnt    = state_q == SERVE0;
    assign m1_gnt    = sel;
    assign m0_rvalid = rvalid0_q;
    assign m1_rvalid = rvalid1_q;
    assign m0_err    = err0_q;
    assign m1_err    = err1_q;
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;

    // Strobes are gated by rst so a store cannot commit in a reset cycle.
    assign mem_we    = serve & we_s & aligned & ~rst;
    assign mem_re    = load_ok & ~rst;
    assign mem_addrs = serve ? addr_s : '0;
    assign mem_data  = serve ? wdata_s : '0;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign pick = ~m0_req;
`else
    assign pick = (m0_req & m1_req) ? ~last_q : m1_req;
`endif

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        lock_cnt_d = lock_cnt_q;
        if (!serve) begin
            if (m0_req | m1_req) begin
                state_d = pick ? SERVE1 : SERVE0;
                last_d  = pick;
            end
        end else if (lock_s & req_s & (lock_cnt_q < CW'(LOCK_MAX - 1))) begin
            lock_cnt_d = lock_cnt_q + 1'b1;
        end else begin
            state_d    = IDLE;
            lock_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            lock_cnt_q <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            err0_q     <= 1'b0;
            err1_q     <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            lock_cnt_q <= lock_cnt_d;
            rvalid0_q  <= m0_gnt;
            rvalid1_q  <= m1_gnt;
            err0_q     <= m0_gnt & ~aligned;
            err1_q     <= m1_gnt & ~aligned;
            if (m0_gnt & load_ok) rdata0_q <= mem_data_out;
            if (m1_gnt & load_ok) rdata1_q <= mem_data_out;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed test-plan steps, then random traffic against a transaction-level model.
module tb_dmem_arbiter;
    localparam int LM = 4;

    logic clk = 1'b0, rst = 1'b1;
    logic m0_req = 0, m0_we = 0, m0_lock = 0, m1_req = 0, m1_we = 0, m1_lock = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
    logic m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err, mem_we, mem_re;
    logic [31:0] m0_rdata, m1_rdata, mem_addrs, mem_data, mem_data_out;

    logic [31:0] mem [0:15];
    logic        pl_en = 1'b0;
    logic [3:0]  pl_idx = 0;
    logic [31:0] pl_val = 0;

    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    assign mem_data_out = mem[mem_addrs[5:2]];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addrs[5:2]] <= mem_data;
        else if (pl_en) mem[pl_idx] <= pl_val;
    end

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .LOCK_MAX(LM)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addrs(mem_addrs), .mem_data(mem_data),
        .mem_data_out(mem_data_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic set0(input logic r, input logic w, input logic l, input logic [31:0] a, input logic [31:0] d);
        m0_req = r; m0_we = w; m0_lock = l; m0_addr = a; m0_wdata = d;
    endtask

    task automatic set1(input logic r, input logic w, input logic l, input logic [31:0] a, input logic [31:0] d);
        m1_req = r; m1_we = w; m1_lock = l; m1_addr = a; m1_wdata = d;
    endtask

    task automatic pl(input int i, input logic [31:0] v);
        pl_en = 1'b1; pl_idx = 4'(i); pl_val = v;
        nxt();
        pl_en = 1'b0;
    endtask

    task automatic do_reset();
        nxt();
        rst = 1'b1;
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        nxt();
        nxt();
        rst = 1'b0;
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, " flags"}, {24'b0, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, mem_we, mem_re}, 32'h0);
        chk({tag, " rdata0"}, m0_rdata, 32'h0);
        chk({tag, " rdata1"}, m1_rdata, 32'h0);
        chk({tag, " addrs"}, mem_addrs, 32'h0);
        chk({tag, " mdata"}, mem_data, 32'h0);
    endtask

    function automatic logic [31:0] gnts();
        return {30'b0, m1_gnt, m0_gnt};
    endfunction

    // Random-phase driver state and reference model
    logic        rq [2], wr [2], lk [2], g [2];
    logic [31:0] ad [2], wd [2], exp_rd [2], refm [0:15];
    int          owner, last, held, prev;
    logic        perr, al;
    logic [1:0]  contend_exp [0:8];
    logic [1:0]  limit_exp [0:6];

    initial begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
        contend_exp = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
        limit_exp   = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01};
`else
        contend_exp = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        limit_exp   = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10};
`endif
        nxt();
        pl(4, 32'hDEADBEEF);
        pl(8, 32'hA5A5A5A5);
        pl(9, 32'h00000011);
        pl(0, 32'h0);
        pl(1, 32'h0);
        smp();
        chk_rst("reset");

        // Single load on port 0
        do_reset();
        set0(1, 0, 0, 32'h10, 0);
        smp(); chk("ld c0 gnt", gnts(), 0);
        nxt(); smp();
        chk("ld c1 gnt", gnts(), 1);
        chk("ld c1 we/re", {30'b0, mem_we, mem_re}, 1);
        chk("ld c1 addr", mem_addrs, 32'h10);
        nxt(); set0(0, 0, 0, 0, 0); smp();
        chk("ld c2 rvalid/err", {30'b0, m0_rvalid, m0_err}, 2);
        chk("ld c2 rdata", m0_rdata, 32'hDEADBEEF);
        chk("ld c2 gnt", gnts(), 0);

        // Continuous contention after reset
        do_reset();
        set0(1, 0, 0, 32'h0, 0);
        set1(1, 0, 0, 32'h4, 0);
        for (int c = 0; c < 9; c++) begin
            smp();
            chk($sformatf("contend c%0d", c), gnts(), 32'(contend_exp[c]));
            nxt();
        end

        // Locked read-modify-write on port 1
        do_reset();
        set0(1, 0, 0, 32'h0, 0);
        set1(1, 0, 1, 32'h20, 0);
        smp(); chk("rmw c0", gnts(), 0);
        nxt(); smp(); chk("rmw c1", gnts(), 1);
        nxt(); set0(0, 0, 0, 0, 0); smp(); chk("rmw c2", gnts(), 0);
        nxt(); set0(1, 0, 0, 32'h0, 0); smp(); chk("rmw c3", gnts(), 2);
        nxt(); set1(1, 1, 0, 32'h20, 32'h5); smp();
        chk("rmw c4 gnt", gnts(), 2);
        chk("rmw c4 we", {31'b0, mem_we}, 1);
        chk("rmw c4 data", mem_data, 32'h5);
        chk("rmw c4 rdata", m1_rdata, 32'hA5A5A5A5);
        nxt(); set1(0, 0, 0, 0, 0); smp();
        chk("rmw c5 gnt", gnts(), 0);
        chk("rmw c5 rvalid/err", {30'b0, m1_rvalid, m1_err}, 2);
        chk("rmw c5 rdata held", m1_rdata, 32'hA5A5A5A5);
        nxt(); smp(); chk("rmw c6", gnts(), 1);
        nxt(); set0(0, 0, 0, 0, 0); set1(1, 0, 0, 32'h20, 0); smp(); chk("rmw c7", gnts(), 0);
        nxt(); smp(); chk("rmw c8", gnts(), 2);
        nxt(); set1(0, 0, 0, 0, 0); smp();
        chk("rmw c9 rvalid", {31'b0, m1_rvalid}, 1);
        chk("rmw c9 rdata", m1_rdata, 32'h5);

        // Lock limit
        do_reset();
        set0(1, 0, 1, 32'h0, 0);
        set1(1, 0, 0, 32'h4, 0);
        for (int c = 0; c < 7; c++) begin
            smp();
            chk($sformatf("limit c%0d", c), gnts(), 32'(limit_exp[c]));
            nxt();
        end
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);

        // Misaligned store
        do_reset();
        set0(1, 1, 0, 32'h13, 32'hFFFF);
        smp();
        nxt(); smp();
        chk("mis gnt", gnts(), 1);
        chk("mis we/re", {30'b0, mem_we, mem_re}, 0);
        nxt(); set0(0, 0, 0, 0, 0); smp();
        chk("mis rvalid/err", {30'b0, m0_rvalid, m0_err}, 3);
        chk("mis mem", mem[4], 32'hDEADBEEF);

        // Reset during a store
        do_reset();
        set1(1, 1, 0, 32'h24, 32'h77);
        smp();
        nxt(); rst = 1'b1; smp();
        chk("rstsrv gnt", gnts(), 2);
        chk("rstsrv we", {31'b0, mem_we}, 0);
        nxt(); smp();
        chk_rst("rstsrv after");
        nxt(); rst = 1'b0; set1(0, 0, 0, 0, 0); smp();
        chk("rstsrv mem", mem[9], 32'h11);

        // Random traffic against the reference model
        nxt(); rst = 1'b1;
        for (int i = 0; i < 16; i++) pl(i, $urandom);
        for (int i = 0; i < 16; i++) refm[i] = mem[i];
        rst = 1'b0;
        owner = -1; last = 1; held = 0; prev = -1; perr = 0;
        for (int k = 0; k < 2; k++) begin
            rq[k] = 0; wr[k] = 0; lk[k] = 0; ad[k] = 0; wd[k] = 0; g[k] = 0; exp_rd[k] = 0;
        end
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int k = 0; k < 2; k++) begin
                if (g[k] || !rq[k]) begin
                    if ($urandom_range(0, 99) < (g[k] ? 60 : 35)) begin
                        rq[k] = 1;
                        wr[k] = 1'($urandom_range(0, 1));
                        lk[k] = $urandom_range(0, 2) == 0;
                        ad[k] = 32'($urandom_range(0, 15)) * 4 + (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
                        wd[k] = $urandom;
                    end else rq[k] = 0;
                end
            end
            set0(rq[0], wr[0], lk[0], ad[0], wd[0]);
            set1(rq[1], wr[1], lk[1], ad[1], wd[1]);
            smp();
            chk("rnd gnt", gnts(), owner == 1 ? 32'd2 : owner == 0 ? 32'd1 : 32'd0);
            if (owner >= 0) begin
                al = ad[owner][1:0] == 2'b00;
                chk("rnd addr", mem_addrs, ad[owner]);
                chk("rnd we/re", {30'b0, mem_we, mem_re}, !al ? 32'd0 : wr[owner] ? 32'd2 : 32'd1);
                if (wr[owner] && al) chk("rnd wdata", mem_data, wd[owner]);
            end
            chk("rnd rvalid", {30'b0, m1_rvalid, m0_rvalid}, prev == 1 ? 32'd2 : prev == 0 ? 32'd1 : 32'd0);
            chk("rnd err", {30'b0, m1_err, m0_err}, (prev == 1 && perr) ? 32'd2 : (prev == 0 && perr) ? 32'd1 : 32'd0);
            chk("rnd rdata0", m0_rdata, exp_rd[0]);
            chk("rnd rdata1", m1_rdata, exp_rd[1]);
            prev = owner;
            if (owner >= 0) begin
                perr = !al;
                if (al && !wr[owner]) exp_rd[owner] = refm[ad[owner][5:2]];
                if (al && wr[owner]) refm[ad[owner][5:2]] = wd[owner];
            end
            if (owner < 0) begin
                if (rq[0] || rq[1]) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
                    owner = rq[0] ? 0 : 1;
`else
                    owner = (rq[0] && rq[1]) ? 1 - last : (rq[1] ? 1 : 0);
`endif
                    last = owner;
                    held = 1;
                end
            end else if (lk[owner] && rq[owner] && held < LM) held++;
            else owner = -1;
            g[0] = m0_gnt;
            g[1] = m1_gnt;
            nxt();
        end
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        nxt(); nxt(); smp();
        for (int i = 0; i < 16; i++) chk($sformatf("rnd mem[%0d]", i), mem[i], refm[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
